tl_ul_sram_responder: RTL and testbench
=======================================

Name: tl_ul_sram_responder

Overview:
- TileLink-UL manager (responder) endpoint: accepts A-channel Get/PutFullData/PutPartialData and returns D-channel AccessAck/AccessAckData.
- Backs a small word-addressed SRAM window; it is the far end of the A/D queue pair that the TL monitor checks.
- One response register gives full one-beat-per-cycle throughput with D-side backpressure.
- Illegal requests are answered with denied responses, never dropped.

Parameters:
- BASE_ADDR, 30'h0200_0000, byte base address of the window; aligned to DEPTH*4.
- DEPTH, 256, number of 32-bit words; power of two, 2..4096.
- SRC_W, 2, width of the source ID.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- a_valid  in  1  A beat valid.
- a_ready  out  1  A beat accepted when a_valid & a_ready.
- a_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get; others illegal.
- a_param  in  3  must be 0.
- a_size  in  2  log2 bytes, 0..2.
- a_source  in  SRC_W  request ID.
- a_address  in  30  byte address.
- a_mask  in  4  byte lanes.
- a_data  in  32  write data.
- a_corrupt  in  1  write data poisoned.
- d_valid  out  1  response valid.
- d_ready  in  1  response taken.
- d_opcode  out  3  0=AccessAck, 1=AccessAckData.
- d_param  out  2  always 0.
- d_size  out  2  echo of a_size.
- d_source  out  SRC_W  echo of a_source.
- d_denied  out  1  request rejected.
- d_data  out  32  read data; 0 unless Get.
- d_corrupt  out  1  read data invalid.

Behaviour:
- Reset: d_valid=0; d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt all 0. SRAM contents undefined; not reset.
- a_ready = !d_valid | d_ready (combinational). Accept = a_valid & a_ready.
- Latency: a request accepted in cycle N has its response valid in cycle N+1. Back-to-back accepts are allowed whenever d_ready=1.
- Holding: while d_valid & !d_ready, all d_* outputs hold stable and a_ready=0.
- Response register: states EMPTY and FULL, encoded by d_valid.
  - EMPTY->FULL on accept.
  - FULL->EMPTY on d_ready with no accept.
  - FULL->FULL on d_ready with an accept in the same cycle; the register reloads.
- Legality: a request is legal only if all of the following hold:
  - opcode is in {0,1,4} and a_param==0;
  - a_size<=2;
  - address is aligned to 2^a_size;
  - BASE_ADDR <= address < BASE_ADDR+DEPTH*4;
  - for Get/PutFull, mask equals the full lane mask for size and address (size 2 ->4'hF; size 1 ->4'h3 or 4'hC; size 0 -> one-hot on address[1:0]);
  - for PutPartial, mask is nonzero and a subset of that full mask.
- Illegal request: no SRAM access; d_denied=1. Illegal Get gives d_opcode=1, d_corrupt=1, d_data=0. An illegal Put or unknown opcode gives d_opcode=0.
- Legal Put: writes the masked bytes at word index (address-BASE_ADDR)>>2 on the accept edge, unless a_corrupt=1; a corrupt Put suppresses the write and is still acked normally. Response: d_opcode=0, d_denied=0.
- Legal Get: reads the full word and registers it into d_data on the accept edge. Response: d_opcode=1, d_corrupt=0. Lanes outside the mask are still returned.
- Read-after-write ordering: a Get accepted the cycle after a Put to the same word returns the new data. No bypass is needed because there is a single port and at most one access per cycle.
- Reset asserted mid-response: d_valid clears on the next edge and the pending response is lost. A write accepted in the same cycle as reset is suppressed.
- Response field echo: d_size and d_source echo the request.

Decomposition:
- Package tl_ul_pkg: A/D opcode localparams (PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACCESS_ACK=0, ACCESS_ACK_DATA=1), a full-lane-mask function (size, addr[1:0]), and an a-channel struct typedef.
- Sub-module tl_ul_req_check: combinational legality decode returning legal and is_get.
- The SRAM array stays inline as a behavioural reg array with byte-lane write.

Test Plan:
- PutFull addr=BASE+0x10, mask=F, data=0xDEADBEEF, source=1, then Get same address -> AccessAck src1 denied=0, then AccessAckData data=0xDEADBEEF, 1 cycle after each accept.
- PutPartial addr=BASE+0x10, mask=4'b0100, data=0x00AA0000 -> following Get returns 0xDEAABEEF.
- Get addr=BASE+DEPTH*4 -> d_opcode=1, denied=1, corrupt=1, data=0; then Get in range confirms the SRAM is unaffected.
- Get size=2 at addr=BASE+2 (misaligned) and opcode=5 -> both denied, no write.
- d_ready held 0 for 5 cycles with a_valid=1 -> a_ready=0 throughout, d_* stable. On d_ready=1, the new request is accepted in the same cycle, and streaming 8 Gets yields 8 responses in 8 cycles.
- reset pulsed while d_valid=1 -> d_valid=0 next cycle; PutFull with a_corrupt=1 -> AccessAck denied=0, and a later Get returns the old data.

Source files
------------

// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions for the SRAM responder: channel opcodes,
// the A-channel request bundle and the natural byte-lane mask helper.
package tl_ul_pkg;

    // A-channel opcodes accepted by the responder
    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;

    // D-channel opcodes produced by the responder
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    // A-channel beat without the source ID (its width is a top-level parameter)
    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [1:0]  size;
        logic [29:0] address;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        corrupt;
    } tl_a_t;

    // Byte lanes a naturally aligned access of 2^size bytes covers; zero for sizes the bus cannot carry
    function automatic logic [3:0] full_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001 << addr_lo;
            2'd1:    m = addr_lo[1] ? 4'hC : 4'h3;
            2'd2:    m = 4'hF;
            default: m = 4'h0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tl_ul_sram_responder_if.sv
// A/D channel pair between a TileLink-UL requester (master) and this responder (slave).
interface tl_ul_sram_responder_if #(
    parameter int SRC_W = 2
) ();

    logic             a_valid;
    logic             a_ready;
    logic [2:0]       a_opcode;
    logic [2:0]       a_param;
    logic [1:0]       a_size;
    logic [SRC_W-1:0] a_source;
    logic [29:0]      a_address;
    logic [3:0]       a_mask;
    logic [31:0]      a_data;
    logic             a_corrupt;

    logic             d_valid;
    logic             d_ready;
    logic [2:0]       d_opcode;
    logic [1:0]       d_param;
    logic [1:0]       d_size;
    logic [SRC_W-1:0] d_source;
    logic             d_denied;
    logic [31:0]      d_data;
    logic             d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output d_ready,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  d_ready,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt
    );

endinterface

// File: rtl/tl_ul_req_check.sv
// Combinational legality decode of one A-channel request against the SRAM window.
module tl_ul_req_check
    import tl_ul_pkg::*;
#(
    parameter logic [29:0] BASE_ADDR = 30'h0200_0000,
    parameter int          DEPTH     = 256
) (
    input  logic [2:0]  i_opcode,
    input  logic [2:0]  i_param,
    input  logic [1:0]  i_size,
    input  logic [29:0] i_address,
    input  logic [3:0]  i_mask,
    output logic        o_legal,
    output logic        o_is_get
);

    localparam logic [29:0] WINDOW_BYTES = 30'(DEPTH * 4);

    logic [30:0] w_offset;
    logic [3:0]  w_full_mask;
    logic        w_op_ok;
    logic        w_in_range;
    logic        w_aligned;
    logic        w_mask_ok;

    assign w_offset    = {1'b0, i_address} - {1'b0, BASE_ADDR};
    assign w_in_range  = !w_offset[30] && (w_offset[29:0] < WINDOW_BYTES);
    assign w_full_mask = full_mask(i_size, i_address[1:0]);
    assign w_op_ok     = ((i_opcode == PUT_FULL) || (i_opcode == PUT_PARTIAL) || (i_opcode == GET))
                         && (i_param == 3'd0);

    // Address must be aligned to the access size; size 3 cannot fit a 32-bit beat
    always_comb begin
        w_aligned = 1'b0;
        case (i_size)
            2'd0:    w_aligned = 1'b1;
            2'd1:    w_aligned = !i_address[0];
            2'd2:    w_aligned = (i_address[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    // Full-width ops need exactly the natural lanes; partial puts need a nonempty subset of them
    always_comb begin
        w_mask_ok = 1'b0;
        case (i_opcode)
            PUT_FULL, GET: w_mask_ok = (i_mask == w_full_mask);
            PUT_PARTIAL:   w_mask_ok = (i_mask != 4'h0) && ((i_mask & ~w_full_mask) == 4'h0);
            default:       w_mask_ok = 1'b0;
        endcase
    end

    assign o_legal  = w_op_ok && w_aligned && w_in_range && w_mask_ok;
    assign o_is_get = (i_opcode == GET);

endmodule

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL manager endpoint backing a word-addressed SRAM window.
// A single response register (empty/full given by d_valid) sustains one beat per cycle.
module tl_ul_sram_responder
    import tl_ul_pkg::*;
#(
    parameter logic [29:0] BASE_ADDR = 30'h0200_0000,
    parameter int          DEPTH     = 256,
    parameter int          SRC_W     = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    tl_ul_sram_responder_if.slave  tl
);

    localparam int IDXW = $clog2(DEPTH);

    tl_a_t            w_a;
    logic             w_legal;
    logic             w_is_get;
    logic             w_a_ready;
    logic             w_accept;
    logic             w_write;
    logic [IDXW-1:0]  w_idx;

    logic             r_d_valid;
    logic [2:0]       r_d_opcode;
    logic [1:0]       r_d_size;
    logic [SRC_W-1:0] r_d_source;
    logic             r_d_denied;
    logic [31:0]      r_d_data;
    logic             r_d_corrupt;

    logic [31:0]      r_mem [DEPTH];

    assign w_a = '{opcode:  tl.a_opcode,
                   param:   tl.a_param,
                   size:    tl.a_size,
                   address: tl.a_address,
                   mask:    tl.a_mask,
                   data:    tl.a_data,
                   corrupt: tl.a_corrupt};

    tl_ul_req_check #(
        .BASE_ADDR (BASE_ADDR),
        .DEPTH     (DEPTH)
    ) u_req_check (
        .i_opcode  (w_a.opcode),
        .i_param   (w_a.param),
        .i_size    (w_a.size),
        .i_address (w_a.address),
        .i_mask    (w_a.mask),
        .o_legal   (w_legal),
        .o_is_get  (w_is_get)
    );

    assign w_a_ready = !r_d_valid || tl.d_ready;
    assign w_accept  = tl.a_valid && w_a_ready;
    assign w_idx     = w_a.address[IDXW+1:2];
    assign w_write   = w_accept && w_legal && !w_is_get && !w_a.corrupt && !reset;

    // Response register: loads on accept, drains when taken with nothing new behind it
    always_ff @(posedge clock) begin
        if (reset) begin
            r_d_valid   <= 1'b0;
            r_d_opcode  <= 3'd0;
            r_d_size    <= 2'd0;
            r_d_source  <= '0;
            r_d_denied  <= 1'b0;
            r_d_data    <= 32'd0;
            r_d_corrupt <= 1'b0;
        end else if (w_accept) begin
            r_d_valid   <= 1'b1;
            r_d_opcode  <= w_is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
            r_d_size    <= w_a.size;
            r_d_source  <= tl.a_source;
            r_d_denied  <= !w_legal;
            r_d_data    <= (w_legal && w_is_get) ? r_mem[w_idx] : 32'd0;
            r_d_corrupt <= w_is_get && !w_legal;
        end else if (tl.d_ready) begin
            r_d_valid   <= 1'b0;
        end
    end

    // SRAM byte-lane write; storage is deliberately never reset
    always_ff @(posedge clock) begin
        if (w_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_a.mask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_a.data[8*b +: 8];
                end
            end
        end
    end

    assign tl.a_ready   = w_a_ready;
    assign tl.d_valid   = r_d_valid;
    assign tl.d_opcode  = r_d_opcode;
    assign tl.d_param   = 2'd0;
    assign tl.d_size    = r_d_size;
    assign tl.d_source  = r_d_source;
    assign tl.d_denied  = r_d_denied;
    assign tl.d_data    = r_d_data;
    assign tl.d_corrupt = r_d_corrupt;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Bench for tl_ul_sram_responder: directed vector table, hand-built handshake
// sequences and randomized traffic, all checked against a transaction-level model.
module tb_tl_ul_sram_responder;

    localparam int unsigned BASE  = 32'h0200_0000;
    localparam int          DEPTH = 256;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  param;
        logic [1:0]  size;
        logic [1:0]  src;
        logic [29:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        corrupt;
    } req_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
        logic [1:0]  size;
        logic [1:0]  src;
    } resp_t;

    typedef struct {
        req_t        req;
        logic [2:0]  expOp;
        logic        expDen;
        logic [31:0] expData;
        logic        expCor;
    } vec_t;

    logic clock = 1'b0;
    logic reset;

    tl_ul_sram_responder_if #(.SRC_W(2)) bus ();

    tl_ul_sram_responder #(
        .BASE_ADDR (30'(BASE)),
        .DEPTH     (DEPTH),
        .SRC_W     (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .tl    (bus)
    );

    always #5 clock = ~clock;

    int    total = 0;
    int    bad   = 0;

    // Stimulus state driven each cycle
    req_t  curReq;
    logic  aValid;
    logic  dReady;
    logic  rst;

    // Model state
    logic [31:0] refMem [DEPTH];
    logic  modelValid   = 1'b0;
    logic  modelZero    = 1'b0;
    logic  started      = 1'b0;
    logic  lastAccepted = 1'b0;
    resp_t modelResp    = '0;

    vec_t  vecs [14];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] refFullMask(input logic [1:0] size, input int unsigned a);
        if (size > 2) return 4'h0;
        return 4'(((32'd1 << (32'd1 << size)) - 32'd1) << (a % 4));
    endfunction

    // Transaction-level reference: decides legality from the rules and updates the model memory
    function automatic resp_t refResp(input req_t r);
        resp_t       rs;
        logic        legal;
        int unsigned a;
        int unsigned idx;
        logic [3:0]  fm;
        a     = 32'(r.addr);
        legal = 1'b1;
        if (!(r.op == 3'd0 || r.op == 3'd1 || r.op == 3'd4) || r.param != 3'd0) legal = 1'b0;
        if (r.size > 2) legal = 1'b0;
        else if ((a % (32'd1 << r.size)) != 0) legal = 1'b0;
        if (a < BASE || a >= BASE + DEPTH * 4) legal = 1'b0;
        fm = refFullMask(r.size, a);
        if (r.op == 3'd0 || r.op == 3'd4) begin
            if (r.mask != fm) legal = 1'b0;
        end else if (r.op == 3'd1) begin
            if (r.mask == 4'h0 || (r.mask & ~fm) != 4'h0) legal = 1'b0;
        end
        rs.opcode  = (r.op == 3'd4) ? 3'd1 : 3'd0;
        rs.denied  = !legal;
        rs.size    = r.size;
        rs.src     = r.src;
        rs.data    = 32'd0;
        rs.corrupt = (r.op == 3'd4) && !legal;
        if (legal) begin
            idx = (a - BASE) / 4;
            if (r.op == 3'd4) rs.data = refMem[idx];
            else if (!r.corrupt) begin
                for (int b = 0; b < 4; b++)
                    if (r.mask[b]) refMem[idx][8*b +: 8] = r.data[8*b +: 8];
            end
        end
        return rs;
    endfunction

    function automatic req_t mkReq(input logic [2:0] op, input logic [1:0] size, input logic [1:0] src,
                                   input int unsigned off, input logic [3:0] mask,
                                   input logic [31:0] data, input logic corrupt);
        req_t r;
        r.op = op; r.param = 3'd0; r.size = size; r.src = src;
        r.addr = 30'(BASE + off); r.mask = mask; r.data = data; r.corrupt = corrupt;
        return r;
    endfunction

    function automatic req_t randReq();
        req_t        r;
        int          k;
        int unsigned off;
        k = $urandom_range(0, 99);
        if (k < 35)      r.op = 3'd4;
        else if (k < 60) r.op = 3'd0;
        else if (k < 85) r.op = 3'd1;
        else             r.op = 3'($urandom_range(0, 7));
        r.param = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        r.size  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        off = $urandom_range(0, DEPTH - 1) * 4;
        if (r.size == 2'd1) off += 2 * $urandom_range(0, 1);
        else if (r.size == 2'd0) off += $urandom_range(0, 3);
        if ($urandom_range(0, 11) == 0) off = (off & ~32'd3) + $urandom_range(0, 3);
        k = $urandom_range(0, 11);
        if (k == 0)      r.addr = 30'(BASE + DEPTH * 4 + off);
        else if (k == 1) r.addr = 30'(BASE - 4 + (off % 4));
        else             r.addr = 30'(BASE + off);
        r.mask = refFullMask(r.size, 32'(r.addr));
        if (r.op == 3'd1) r.mask = r.mask & 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) r.mask = 4'($urandom_range(0, 15));
        r.src     = 2'($urandom_range(0, 3));
        r.data    = $urandom;
        r.corrupt = ($urandom_range(0, 9) == 0);
        return r;
    endfunction

    // Compare every DUT output against the model for the current cycle
    task automatic checkOutput();
        if (!started) return;
        checkVal("a_ready", 32'(bus.a_ready), 32'(!modelValid || dReady));
        checkVal("d_valid", 32'(bus.d_valid), 32'(modelValid));
        if (modelValid || modelZero) begin
            checkVal("d_opcode",  32'(bus.d_opcode),  32'(modelResp.opcode));
            checkVal("d_param",   32'(bus.d_param),   32'd0);
            checkVal("d_size",    32'(bus.d_size),    32'(modelResp.size));
            checkVal("d_source",  32'(bus.d_source),  32'(modelResp.src));
            checkVal("d_denied",  32'(bus.d_denied),  32'(modelResp.denied));
            checkVal("d_data",    bus.d_data,         modelResp.data);
            checkVal("d_corrupt", 32'(bus.d_corrupt), 32'(modelResp.corrupt));
        end
    endtask

    // Drive one cycle from a falling edge, check, then advance the model across the rising edge
    task automatic applyStimulus();
        logic acc;
        bus.a_valid   = aValid;
        bus.a_opcode  = curReq.op;
        bus.a_param   = curReq.param;
        bus.a_size    = curReq.size;
        bus.a_source  = curReq.src;
        bus.a_address = curReq.addr;
        bus.a_mask    = curReq.mask;
        bus.a_data    = curReq.data;
        bus.a_corrupt = curReq.corrupt;
        bus.d_ready   = dReady;
        reset         = rst;
        #1;
        checkOutput();
        @(posedge clock);
        acc = aValid && (!modelValid || dReady);
        lastAccepted = 1'b0;
        if (rst) begin
            modelValid = 1'b0;
            modelZero  = 1'b1;
            modelResp  = '0;
            started    = 1'b1;
        end else if (acc) begin
            modelResp    = refResp(curReq);
            modelValid   = 1'b1;
            modelZero    = 1'b0;
            lastAccepted = 1'b1;
        end else if (dReady) begin
            modelValid = 1'b0;
        end
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = '{mkReq(3'd0, 2'd2, 2'd1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0), 3'd0, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{mkReq(3'd4, 2'd2, 2'd1, 32'h10, 4'hF, 32'h0,        1'b0), 3'd1, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{mkReq(3'd1, 2'd2, 2'd2, 32'h10, 4'h4, 32'h00AA0000, 1'b0), 3'd0, 1'b0, 32'h0,        1'b0};
        vecs[3]  = '{mkReq(3'd4, 2'd2, 2'd3, 32'h10, 4'hF, 32'h0,        1'b0), 3'd1, 1'b0, 32'hDEAABEEF, 1'b0};
        vecs[4]  = '{mkReq(3'd4, 2'd2, 2'd0, DEPTH*4, 4'hF, 32'h0,       1'b0), 3'd1, 1'b1, 32'h0,        1'b1};
        vecs[5]  = '{mkReq(3'd4, 2'd2, 2'd1, 32'h10, 4'hF, 32'h0,        1'b0), 3'd1, 1'b0, 32'hDEAABEEF, 1'b0};
        vecs[6]  = '{mkReq(3'd4, 2'd2, 2'd2, 32'h2,  4'hF, 32'h0,        1'b0), 3'd1, 1'b1, 32'h0,        1'b1};
        vecs[7]  = '{mkReq(3'd5, 2'd2, 2'd3, 32'h10, 4'hF, 32'h12345678, 1'b0), 3'd0, 1'b1, 32'h0,        1'b0};
        vecs[8]  = '{mkReq(3'd0, 2'd2, 2'd0, DEPTH*4, 4'hF, 32'h55555555, 1'b0), 3'd0, 1'b1, 32'h0,       1'b0};
        vecs[9]  = '{mkReq(3'd4, 2'd0, 2'd1, 32'h11, 4'h2, 32'h0,        1'b0), 3'd1, 1'b0, 32'hDEAABEEF, 1'b0};
        vecs[10] = '{mkReq(3'd4, 2'd2, 2'd2, 32'h10, 4'hF, 32'h0,        1'b0), 3'd1, 1'b0, 32'hDEAABEEF, 1'b0};
        vecs[11] = '{mkReq(3'd0, 2'd1, 2'd3, 32'h12, 4'hC, 32'h12340000, 1'b0), 3'd0, 1'b0, 32'h0,        1'b0};
        vecs[12] = '{mkReq(3'd4, 2'd2, 2'd0, 32'h10, 4'hF, 32'h0,        1'b0), 3'd1, 1'b0, 32'h1234BEEF, 1'b0};
        vecs[13] = '{mkReq(3'd1, 2'd2, 2'd1, 32'h10, 4'h0, 32'hFFFFFFFF, 1'b0), 3'd0, 1'b1, 32'h0,        1'b0};

        curReq = '0;
        aValid = 1'b0;
        dReady = 1'b1;
        rst    = 1'b1;
        @(negedge clock);

        // Reset, then confirm the cleared response register
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        applyStimulus();

        // Fill the whole window so every later read has a known value
        for (int w = 0; w < DEPTH; w++) begin
            curReq = mkReq(3'd0, 2'd2, 2'($urandom_range(0, 3)), 32'(w * 4), 4'hF, $urandom, 1'b0);
            aValid = 1'b1;
            applyStimulus();
        end
        aValid = 1'b0;
        applyStimulus();

        // Directed vector table: response one cycle after each accept
        for (int i = 0; i < 14; i++) begin
            curReq = vecs[i].req;
            aValid = 1'b1;
            dReady = 1'b1;
            applyStimulus();
            aValid      = 1'b0;
            bus.a_valid = 1'b0;
            #1;
            checkVal($sformatf("vec%0d d_valid", i),   32'(bus.d_valid),   32'd1);
            checkVal($sformatf("vec%0d d_opcode", i),  32'(bus.d_opcode),  32'(vecs[i].expOp));
            checkVal($sformatf("vec%0d d_denied", i),  32'(bus.d_denied),  32'(vecs[i].expDen));
            checkVal($sformatf("vec%0d d_data", i),    bus.d_data,         vecs[i].expData);
            checkVal($sformatf("vec%0d d_corrupt", i), 32'(bus.d_corrupt), 32'(vecs[i].expCor));
            checkVal($sformatf("vec%0d d_size", i),    32'(bus.d_size),    32'(vecs[i].req.size));
            checkVal($sformatf("vec%0d d_source", i),  32'(bus.d_source),  32'(vecs[i].req.src));
            applyStimulus();
        end

        // Backpressure: response held and a_ready low for 5 cycles, then streaming Gets
        dReady = 1'b0;
        aValid = 1'b1;
        curReq = mkReq(3'd4, 2'd2, 2'd1, 32'h10, 4'hF, 32'h0, 1'b0);
        applyStimulus();
        curReq = mkReq(3'd4, 2'd2, 2'd2, 32'h40, 4'hF, 32'h0, 1'b0);
        for (int s = 0; s < 5; s++) begin
            applyStimulus();
            checkVal("held d_data", bus.d_data, 32'h1234BEEF);
        end
        dReady = 1'b1;
        applyStimulus();
        for (int g = 0; g < 8; g++) begin
            curReq = mkReq(3'd4, 2'd2, 2'(g), 32'(g * 8), 4'hF, 32'h0, 1'b0);
            applyStimulus();
        end
        aValid = 1'b0;
        applyStimulus();

        // Reset while a response is pending, with a write offered in the same cycle
        dReady = 1'b0;
        aValid = 1'b1;
        curReq = mkReq(3'd4, 2'd2, 2'd3, 32'h20, 4'hF, 32'h0, 1'b0);
        applyStimulus();
        rst    = 1'b1;
        dReady = 1'b1;
        curReq = mkReq(3'd0, 2'd2, 2'd1, 32'h20, 4'hF, 32'hCAFEF00D, 1'b0);
        applyStimulus();
        rst    = 1'b0;
        aValid = 1'b0;
        applyStimulus();
        checkVal("post-reset d_valid", 32'(bus.d_valid), 32'd0);
        aValid = 1'b1;
        curReq = mkReq(3'd4, 2'd2, 2'd0, 32'h20, 4'hF, 32'h0, 1'b0);
        applyStimulus();
        curReq = mkReq(3'd0, 2'd2, 2'd2, 32'h20, 4'hF, 32'h0BADF00D, 1'b1);
        applyStimulus();
        curReq = mkReq(3'd4, 2'd2, 2'd3, 32'h20, 4'hF, 32'h0, 1'b0);
        applyStimulus();
        aValid = 1'b0;
        applyStimulus();

        // Randomized traffic with random D-side stalls; requests hold until accepted
        for (int c = 0; c < 400; c++) begin
            if (!aValid || lastAccepted) begin
                curReq = randReq();
                aValid = ($urandom_range(0, 4) != 0);
            end
            dReady = ($urandom_range(0, 3) != 0);
            applyStimulus();
        end
        aValid = 1'b0;
        dReady = 1'b1;
        applyStimulus();
        applyStimulus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
